fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage of the 16-bit pipelined CPU, directly upstream of decode.
//  Owns the PC, drives the synchronous instruction ROM and fills the fetch/decode pipeline register.
//  Handles decode-side stall, execute-side branch redirect and a HALT opcode; emits bubbles as valid_decode=0.
// PARAMETERS
//  PC_W        8         PC / imem address width (word-addressed; one 16-bit instruction per word)
//  RESET_PC    'h0       PC value loaded on reset
//  NOP_INSTR   16'h0000  instruction_decode value whenever valid_decode=0
//  HALT_OP     4'hF      opcode [15:12] that stops fetch
// PORTS
//  clk                 in   1     clock; all state updates on rising edge
//  rst                 in   1     synchronous, active-high reset
//  stall               in   1     hazard hold from decode; freeze stage
//  branch_taken        in   1     redirect request from execute
//  branch_target       in   PC_W  redirect address
//  imem_addr           out  PC_W  ROM read address (combinational)
//  imem_rdata          in   16    ROM data; 1-cycle latency after imem_addr
//  instruction_decode  out  16    instruction to decode (registered)
//  pc_decode           out  PC_W  PC of instruction_decode (registered)
//  valid_decode        out  1     instruction_decode is real (not a bubble)
//  halted              out  1     FSM in HALT
// BEHAVIOUR
//  - Regs: pc_q (next fetch addr), req_pc_q/req_valid_q (in-flight ROM read), decode regs, state.
//  - Reset: pc_q=RESET_PC, req_valid_q=0, req_pc_q=0, instruction_decode=NOP_INSTR, pc_decode=0, valid_decode=0, state=RUN, halted=0.
//  - imem_addr = (stall && !branch_taken) ? req_pc_q : pc_q  (re-read on stall keeps imem_rdata valid).
//  - Latency: address issued cycle t -> valid_decode/instruction_decode visible cycle t+2; first valid 2 cycles after rst falls.
//  - Priority per edge: rst > branch_taken > stall > normal.
//  - Normal (RUN): pc_q<=pc_q+1 (mod 2^PC_W, wraps max->0); req_pc_q<=pc_q; req_valid_q<=1;
//    decode regs <= {imem_rdata, req_pc_q, req_valid_q}; if !req_valid_q, instruction_decode<=NOP_INSTR.
//  - stall (no redirect): every register holds; imem_addr re-issues req_pc_q; no instruction lost or duplicated.
//  - branch_taken: pc_q<=branch_target; req_valid_q<=0; valid_decode<=0, instruction_decode<=NOP_INSTR;
//    state<=RUN (also leaves HALT); overrides simultaneous stall. First target instr valid 2 cycles later.
//  - HALT detect: normal edge with req_valid_q=1 and imem_rdata[15:12]==HALT_OP -> halt instr forwarded valid,
//    state<=HALT, req_valid_q<=0, pc_q holds (squashes in-flight successor).
//  - HALT: pc_q, req_pc_q hold; req_valid_q=0; valid_decode=0 from next edge; halted=1; exit only via rst or branch_taken.
//  - No X on outputs at any time after first reset edge.
// CONFIGURATION
//  FETCH_PERF_EN defined: extra out ports perf_fetched[15:0] (+1 per edge valid_decode is written 1) and
//    perf_stall[15:0] (+1 per cycle stall=1 and state==RUN); both reset to 0, saturate at 16'hFFFF.
//  Undefined: ports and counters absent; remaining behaviour identical.
// STRUCTURE
//  cpu_pkg: opcode_t (logic [3:0]), instr_t (logic [15:0]), fetch_state_e {F_RUN, F_HALT}, OP_HALT constant.
//  Sub-module fetch_pc_reg: pc_q with increment/redirect/hold mux and wrap; rest (request + decode regs, FSM) in fetch_stage.
// TESTING
//  1 Reset, ROM[i]=16'h8000|i, no stall: valid_decode rises cycle 2; pc_decode 0,1,2,3... consecutive, no gaps.
//  2 stall=1 for 3 cycles while pc_decode=5: outputs hold instr 5 all 3 cycles; after release, 6 follows, no skip/dup.
//  3 branch_taken, target=8'h40, at pc_decode=3: next cycle valid_decode=0; ROM[0x40] valid 2 cycles after redirect.
//  4 branch_taken and stall same cycle: redirect wins; same response as scenario 3.
//  5 ROM[6]=16'hF000: instr 6 delivered valid, halted=1 next edge, valid_decode=0 thereafter; branch to 0 resumes.
//  6 RESET_PC=8'hFE: pc_decode FE, FF, 00 (wrap); rst mid-stream -> all outputs back to reset values next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the 16-bit pipelined CPU.
// Opcode/instruction aliases and the fetch FSM encoding.
package cpu_pkg;

  typedef logic [3:0]  opcode_t;
  typedef logic [15:0] instr_t;

  typedef enum logic {
    F_RUN  = 1'b0,
    F_HALT = 1'b1
  } fetch_state_e;

  localparam opcode_t OP_HALT = 4'hF;

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch program counter: reset, redirect, hold or increment.
// Increment wraps naturally at 2^PC_W.
module fetch_pc_reg #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            redirect,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst)
      pc <= RESET_PC;
    else if (redirect)
      pc <= target;
    else if (!hold)
      pc <= pc + PC_W'(1);
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, ROM request and fetch/decode register.
// Define FETCH_PERF_EN to add perf_fetched / perf_stall counters.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int              PC_W      = 8,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter instr_t          NOP_INSTR = 16'h0000,
  parameter opcode_t         HALT_OP   = OP_HALT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] imem_addr,
  input  instr_t          imem_rdata,
  output instr_t          instruction_decode,
  output logic [PC_W-1:0] pc_decode,
  output logic            valid_decode,
  output logic            halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]     perf_fetched,
  output logic [15:0]     perf_stall
`endif
);

  fetch_state_e    state;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] req_pc_q;
  logic            req_valid_q;
  logic            run;
  logic            halt_hit;
  logic            pc_hold;

  assign run      = (state == F_RUN);
  assign halt_hit = run && req_valid_q
                 && (opcode_t'(imem_rdata[15:12]) == HALT_OP);
  assign pc_hold  = stall || !run || halt_hit;
  assign halted   = (state == F_HALT);

  // Re-reading the in-flight address keeps imem_rdata valid across a stall.
  assign imem_addr = (stall && !branch_taken) ? req_pc_q : pc_q;

  fetch_pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .hold     (pc_hold),
    .redirect (branch_taken),
    .target   (branch_target),
    .pc       (pc_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= F_RUN;
      req_pc_q           <= '0;
      req_valid_q        <= 1'b0;
      instruction_decode <= NOP_INSTR;
      pc_decode          <= '0;
      valid_decode       <= 1'b0;
    end else if (branch_taken) begin
      state              <= F_RUN;
      req_valid_q        <= 1'b0;
      instruction_decode <= NOP_INSTR;
      valid_decode       <= 1'b0;
    end else if (!stall) begin
      if (!run) begin
        instruction_decode <= NOP_INSTR;
        valid_decode       <= 1'b0;
      end else begin
        pc_decode          <= req_pc_q;
        valid_decode       <= req_valid_q;
        instruction_decode <= req_valid_q ? imem_rdata : NOP_INSTR;
        if (halt_hit) begin
          state       <= F_HALT;
          req_valid_q <= 1'b0;
        end else begin
          req_pc_q    <= pc_q;
          req_valid_q <= 1'b1;
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic fetch_ev;
  logic stall_ev;

  assign fetch_ev = !branch_taken && !stall && run && req_valid_q;
  assign stall_ev = stall && run;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (fetch_ev && perf_fetched != 16'hFFFF)
        perf_fetched <= perf_fetched + 16'd1;
      if (stall_ev && perf_stall != 16'hFFFF)
        perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule
